// File: rtl/scrypt_pkg.sv
// rtl/scrypt_pkg.sv - shared sizing constants and FSM state type for the ROMix scratchpad controller
package scrypt_pkg;

  localparam int N_BLOCKS  = 1024;
  localparam int ADDR_W    = 17;
  localparam int BLK_BITS  = 1024;
  // One block is 128 bytes, so a block index becomes a byte address by a 7-bit shift.
  localparam int BLK_SHIFT = 7;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WRITE    = 3'd1,
    S_RD_IDX   = 3'd2,
    S_RD_ISSUE = 3'd3,
    S_RD_CAP   = 3'd4,
    S_RD_RESP  = 3'd5,
    S_DONE     = 3'd6
  } state_e;

endpackage

// File: rtl/romix_mem_ctrl_if.sv
// rtl/romix_mem_ctrl_if.sv - handshake and scratchpad bus bundle for the ROMix memory controller
interface romix_mem_ctrl_if #(
  parameter int N_BLOCKS = scrypt_pkg::N_BLOCKS,
  parameter int ADDR_W   = scrypt_pkg::ADDR_W,
  parameter int BLK_BITS = scrypt_pkg::BLK_BITS
);

  localparam int IDX_W = $clog2(N_BLOCKS);

  // Control and status
  logic                start;
  logic                busy;
  logic                done;

  // Write phase: blocks X stored as V[i]
  logic                blk_valid;
  logic                blk_ready;
  logic [BLK_BITS-1:0] blk_data;

  // Read phase: index j in, block V[j] out
  logic                idx_valid;
  logic                idx_ready;
  logic [IDX_W-1:0]    idx;
  logic                rd_valid;
  logic                rd_ready;
  logic [BLK_BITS-1:0] rd_data;

  // Scratchpad port (memory lives in the parent)
  logic                r_enable;
  logic                w_enable;
  logic [ADDR_W-1:0]   addr;
  logic [BLK_BITS-1:0] w_data;
  logic [BLK_BITS-1:0] r_data;

  modport slave (
    input  start, blk_valid, blk_data, idx_valid, idx, rd_ready, r_data,
    output busy, done, blk_ready, idx_ready, rd_valid, rd_data,
           r_enable, w_enable, addr, w_data
  );

  modport master (
    output start, blk_valid, blk_data, idx_valid, idx, rd_ready, r_data,
    input  busy, done, blk_ready, idx_ready, rd_valid, rd_data,
           r_enable, w_enable, addr, w_data
  );

endinterface

// File: rtl/romix_mem_ctrl.sv
// rtl/romix_mem_ctrl.sv - ROMix scratchpad sequencer: fill V[0..N-1], then serve N indexed reads
module romix_mem_ctrl #(
  parameter int N_BLOCKS = scrypt_pkg::N_BLOCKS,
  parameter int ADDR_W   = scrypt_pkg::ADDR_W,
  parameter int BLK_BITS = scrypt_pkg::BLK_BITS
) (
  input  logic              clk,
  input  logic              n_rst,
  romix_mem_ctrl_if.slave   bus
);

  import scrypt_pkg::*;

  localparam int IDX_W = $clog2(N_BLOCKS);
  // One spare bit so a count of N never aliases back to zero within a pass.
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BLOCKS - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    wc_q, wc_d;
  logic [CNT_W-1:0]    rc_q, rc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BLK_BITS-1:0] w_data_q, w_data_d;
  logic [BLK_BITS-1:0] rd_data_q, rd_data_d;
  logic                w_en_q, w_en_d;

  logic                blk_acc;
  logic                idx_acc;
  logic                rd_acc;

  // Block index to byte address; bits above the index stay zero.
  function automatic logic [ADDR_W-1:0] blk_addr(input logic [IDX_W-1:0] i);
    return ADDR_W'({i, {BLK_SHIFT{1'b0}}});
  endfunction

  assign blk_acc = (state_q == S_WRITE)   && bus.blk_valid;
  assign idx_acc = (state_q == S_RD_IDX)  && bus.idx_valid;
  assign rd_acc  = (state_q == S_RD_RESP) && bus.rd_ready;

  // Next-state and datapath update; addr/w_data only move on an issuing cycle.
  always_comb begin
    state_d   = state_q;
    wc_d      = wc_q;
    rc_d      = rc_q;
    addr_d    = addr_q;
    w_data_d  = w_data_q;
    rd_data_d = rd_data_q;
    w_en_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_WRITE;
          wc_d    = '0;
        end
      end
      S_WRITE: begin
        if (blk_acc) begin
          // Write is issued the cycle after accept, so consecutive accepts stream without bubbles.
          w_en_d   = 1'b1;
          addr_d   = blk_addr(wc_q[IDX_W-1:0]);
          w_data_d = bus.blk_data;
          wc_d     = wc_q + CNT_W'(1);
          if (wc_q == LAST_CNT) begin
            state_d = S_RD_IDX;
            rc_d    = '0;
          end
        end
      end
      S_RD_IDX: begin
        if (idx_acc) begin
          addr_d  = blk_addr(bus.idx);
          state_d = S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: begin
        state_d = S_RD_CAP;
      end
      S_RD_CAP: begin
        // Scratchpad read data is valid one cycle after the strobe.
        rd_data_d = bus.r_data;
        state_d   = S_RD_RESP;
      end
      S_RD_RESP: begin
        if (rd_acc) begin
          rc_d    = rc_q + CNT_W'(1);
          state_d = (rc_q == LAST_CNT) ? S_DONE : S_RD_IDX;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any pass in progress.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      wc_q      <= '0;
      rc_q      <= '0;
      addr_q    <= '0;
      w_data_q  <= '0;
      rd_data_q <= '0;
      w_en_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wc_q      <= wc_d;
      rc_q      <= rc_d;
      addr_q    <= addr_d;
      w_data_q  <= w_data_d;
      rd_data_q <= rd_data_d;
      w_en_q    <= w_en_d;
    end
  end

  // Handshake readiness and strobes decode straight from state, so reset clears them at once.
  assign bus.blk_ready = (state_q == S_WRITE);
  assign bus.idx_ready = (state_q == S_RD_IDX);
  assign bus.rd_valid  = (state_q == S_RD_RESP);
  assign bus.r_enable  = (state_q == S_RD_ISSUE);
  assign bus.w_enable  = w_en_q;
  assign bus.addr      = addr_q;
  assign bus.w_data    = w_data_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);

endmodule
